hs4_rx_fifo: RTL

- Downstream consumer of the CPU-side 4-phase send/ack data link.
- Captures each word offered on dados/send, answers with ack, and buffers words in a small FIFO.
- Presents buffered words on a valid/ready stream to the next stage.
- Exposes its handshake state and a count of accepted words for debug.

---
 rtl/hs4_rx_fifo_pkg.sv | 12 +
 rtl/hs4_rx_fifo_sync_fifo.sv | 50 +++++
 rtl/hs4_rx_fifo.sv | 75 +++++++
 3 files changed

// File: rtl/hs4_rx_fifo_pkg.sv
// Handshake state encoding shared with the CPU-side send/ack FSM, plus default data width.
package hs4_rx_fifo_pkg;

  localparam int DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    ST_SYNC = 2'b00,
    ST_IDLE = 2'b01,
    ST_ACK  = 2'b10
  } hs_state_t;

endpackage

// File: rtl/hs4_rx_fifo_sync_fifo.sv
// Generic DATA_W x DEPTH synchronous FIFO; push ignored when full, pop ignored when empty.
// Head word is combinational; a pushed word is visible the cycle after the push edge.
module sync_fifo
  import hs4_rx_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one wrap bit so full and empty stay distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hs4_rx_fifo.sv
// 4-phase send/ack receiver feeding a FIFO drained over valid/ready; ack rises 1 cycle after send.
// When the FIFO is full the word is left unacknowledged in IDLE, stalling the sender until space frees.
module hs4_rx_fifo
  import hs4_rx_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          dados,
  input  logic                       send,
  output logic                       ack,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           rx_count,
  output logic [1:0]                 estado
);

  hs_state_t state_q;
  hs_state_t state_d;
  logic      push;
  logic      fifo_full;
  logic      fifo_empty;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_SYNC: if (!send) state_d = ST_IDLE;
      ST_IDLE: begin
        // Full is judged on the start-of-cycle level, so a same-cycle pop does not admit the word.
        if (send && !fifo_full) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  if (!send) state_d = ST_IDLE;
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      rx_count <= '0;
    end else begin
      state_q <= state_d;
      if (push) rx_count <= rx_count + 1'b1;
    end
  end

  assign ack       = (state_q == ST_ACK);
  assign estado    = state_q;
  assign out_valid = !fifo_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (dados),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule
